// File: rtl/cnn_stream_packer_if.sv
// Stream bundle between a word producer, the packer, and a wide-beat consumer.
// The producer/consumer side uses master; the packer uses slave.
interface cnn_stream_packer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 512
);
  localparam int RATIO = OUT_W / IN_W;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_bits;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [RATIO-1:0]  out_keep;
  logic              out_last;

  modport master (
    output in_valid, in_bits, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_bits, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/cnn_stream_packer.sv
// Packs IN_W-bit words into OUT_W-bit beats, lane 0 first, with frame tracking.
// One-cycle latency from the completing word to out_valid; stalls input only while a beat waits.
module cnn_stream_packer #(
  parameter int IN_W        = 64,
  parameter int OUT_W       = 512,
  parameter int FRAME_BEATS = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  cnn_stream_packer_if.slave    bus,
  output logic [15:0]           frames_done
);
  localparam int RATIO  = OUT_W / IN_W;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int STG_W  = (RATIO > 1) ? (RATIO - 1) * IN_W : IN_W;

  if ((OUT_W % IN_W) != 0 || RATIO < 2 || FRAME_BEATS < 1) begin : g_bad_params
    $error("cnn_stream_packer: illegal IN_W/OUT_W/FRAME_BEATS combination");
  end

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [RATIO-1:0]  out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic [15:0]       frames_q, frames_d;

  logic              in_rdy, in_fire, out_fire, beat_done, beat_last;
  logic [OUT_W-1:0]  stage_ext, beat_data;
  logic [RATIO-1:0]  beat_keep;

  assign in_rdy    = !out_valid_q || bus.out_ready;
  assign in_fire   = bus.in_valid && in_rdy;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign beat_done = in_fire && (lane_q == LANE_W'(RATIO - 1) || bus.in_last);
  assign beat_last = (beat_q == BEAT_W'(FRAME_BEATS - 1)) || bus.in_last;
  assign stage_ext = {{IN_W{1'b0}}, stage_q};

  // Lanes below the current one come from staging, the current lane is the live word.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (LANE_W'(k) < lane_q) begin
        beat_data[k*IN_W +: IN_W] = stage_ext[k*IN_W +: IN_W];
      end else if (LANE_W'(k) == lane_q) begin
        beat_data[k*IN_W +: IN_W] = bus.in_bits;
      end
      beat_keep[k] = (LANE_W'(k) <= lane_q);
    end
  end

  always_comb begin
    lane_d      = lane_q;
    stage_d     = stage_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    frames_d    = frames_q;

    if (in_fire && !beat_done) begin
      lane_d = lane_q + 1'b1;
      for (int k = 0; k < RATIO - 1; k++) begin
        if (lane_q == LANE_W'(k)) begin
          stage_d[k*IN_W +: IN_W] = bus.in_bits;
        end
      end
    end

    if (beat_done) begin
      lane_d      = '0;
      beat_d      = beat_last ? '0 : beat_q + 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_keep_d  = beat_keep;
      out_last_d  = beat_last;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (out_fire && out_last_q) begin
      frames_d = frames_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q      <= '0;
      stage_q     <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      frames_q    <= '0;
    end else begin
      lane_q      <= lane_d;
      stage_q     <= stage_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      frames_q    <= frames_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign frames_done   = frames_q;
endmodule
